ecc_read_scrubber: RTL
======================

ECC_READ_SCRUBBER -- requirements
Module: ecc_read_scrubber

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: memory word-address width.
REQ-002 SHALL have parameter SCRUB_EN, default 1: 1 = write back corrected words on single-bit errors, 0 = never write.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: a read request is present.
REQ-006 SHALL have port req_addr, input, ADDR_W: address of the request.
REQ-007 SHALL have port req_ready, output, 1: the block accepts the request.
REQ-008 SHALL have port mem_rd_en, output, 1: memory read strobe.
REQ-009 SHALL have port mem_wr_en, output, 1: memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W: memory address.
REQ-011 SHALL have port mem_wdata, output, 39: code word to write back.
REQ-012 SHALL have port mem_rdata, input, 39: memory read data, valid the cycle after mem_rd_en.
REQ-013 SHALL have port rsp_valid, output, 1: a response is present.
REQ-014 SHALL have port rsp_ready, input, 1: the consumer accepts the response.
REQ-015 SHALL have port rsp_data, output, 32: corrected data word.
REQ-016 SHALL have port rsp_serr, output, 1: a single-bit error was corrected.
REQ-017 SHALL have port rsp_derr, output, 1: the error is uncorrectable.
REQ-018 SHALL have port serr_cnt, output, 16: saturating count of single-bit errors.
REQ-019 SHALL have port derr_cnt, output, 16: saturating count of uncorrectable errors.
REQ-020 SHALL have port last_err_addr, output, ADDR_W: address of the most recent error of either type.
REQ-021 SHALL have port clr_cnt, input, 1: synchronous clear of both counters.

Function
REQ-022 Code word layout SHALL be: [31:0] data; [37:32] check bits p1,p2,p4,p8,p16,p32; [38] overall parity.
REQ-023 Data bits 0..31 SHALL occupy Hamming positions 3,5,6,7,9..15,17..31,33..38 in ascending order.
REQ-024 Check bit pK SHALL be the XOR of all data bits whose Hamming position has bit K set.
REQ-025 Bit 38 SHALL make the XOR of all 39 bits equal 0.
REQ-026 syn[5:0] SHALL be the recomputed check bits XOR the stored bits [37:32]; par SHALL be the XOR of all 39 bits.
REQ-027 The decode cases SHALL be:
 - syn=0, par=0: clean.
 - syn=0, par=1: single error in bit 38; data unchanged.
 - syn a power of two, par=1: single error in a check bit; data unchanged.
 - syn a data position <=38, par=1: single error; flip the mapped data bit.
 - syn>38, par=1: uncorrectable.
 - syn!=0, par=0: uncorrectable.
REQ-028 For uncorrectable words, rsp_data SHALL equal the raw data bits [31:0].
REQ-029 The FSM states SHALL be IDLE, READ, CHECK, WB, RESP.
REQ-030 In IDLE, req_ready SHALL be 1 and req_ready SHALL be 0 in every other state; when req_valid=1 the block SHALL latch req_addr and go to READ.
REQ-031 In READ, the block SHALL drive mem_rd_en=1 with mem_addr set to the latched address for exactly one cycle, then go to CHECK.
REQ-032 In CHECK, the block SHALL register mem_rdata, decode it, and register the data and flags.
REQ-033 From CHECK, the block SHALL go to WB on a single error with SCRUB_EN=1, else to RESP.
REQ-034 In WB, the block SHALL drive mem_wr_en=1 for exactly one cycle, with mem_addr set to the latched address and mem_wdata set to the fully re-encoded corrected word, then go to RESP.
REQ-035 In RESP, rsp_valid SHALL be 1 and rsp_data, rsp_serr and rsp_derr SHALL be held stable until rsp_ready=1; on that cycle the block SHALL go to IDLE.
REQ-036 Latency from the req handshake edge to rsp_valid SHALL be 3 cycles, or 4 cycles when a write-back occurs.
REQ-037 mem_rd_en and mem_wr_en SHALL never be 1 in the same cycle.
REQ-038 In CHECK, each error SHALL increment the matching counter once and update last_err_addr.
REQ-039 Counters SHALL saturate at 16'hFFFF.
REQ-040 When clr_cnt=1, both counters SHALL be 0 next cycle; clr_cnt SHALL override a simultaneous increment.

Reset
REQ-041 While rst_n=0, the FSM SHALL be in IDLE and req_ready SHALL be 0.
REQ-042 While rst_n=0, these outputs SHALL be 0: mem_rd_en, mem_wr_en, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_serr, rsp_derr.
REQ-043 While rst_n=0, serr_cnt, derr_cnt and last_err_addr SHALL be 0.
REQ-044 Reset asserted mid-operation SHALL abort it immediately, with no further strobes and no response.
REQ-045 req_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Verification
REQ-046 All-zero code word at addr 5 -> rsp_data=0, no flags, mem_wr_en never 1, latency 3.
REQ-047 Encoded 0xDEADBEEF with bit 0 flipped, at addr 9:
 - rsp_data=0xDEADBEEF and rsp_serr=1.
 - One write to addr 9 of the clean code word.
 - serr_cnt=1 and last_err_addr=9.
REQ-048 Encoded 0xDEADBEEF with bit 38 flipped -> rsp_data=0xDEADBEEF, rsp_serr=1, write-back of the clean word; repeat with SCRUB_EN=0 -> no write, latency 3.
REQ-049 Encoded 0x12345678 with bits 3 and 7 flipped -> rsp_derr=1, rsp_data equal to the raw bits, no write, derr_cnt=1.
REQ-050 rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0, no memory strobes.
REQ-051 Counter edge cases:
 - serr_cnt preloaded to 0xFFFF plus a single error -> remains 0xFFFF.
 - clr_cnt in the same cycle as an increment -> 0.
 - rst_n low during WB -> no response.

Source files
------------

// File: rtl/ecc_read_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : ecc_read_scrubber
// Brief    : SECDED (39,32) memory read path with optional single-bit scrub
//            write-back, error flags, saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_read_scrubber #(
    parameter int ADDR_W   = 10,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [38:0]       mem_wdata,
    input  logic [38:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_serr,
    output logic              rsp_derr,
    output logic [15:0]       serr_cnt,
    output logic [15:0]       derr_cnt,
    output logic [ADDR_W-1:0] last_err_addr,
    input  logic              clr_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WB    = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_err_addr;
    logic [31:0]       r_data;
    logic              r_serr;
    logic              r_derr;
    logic [38:0]       r_wdata;
    logic [15:0]       r_serr_cnt;
    logic [15:0]       r_derr_cnt;

    logic [5:0]        w_syn;
    logic              w_par;
    logic [31:0]       w_cor_data;
    logic              w_serr;
    logic              w_derr;
    logic [38:0]       w_wdata;

    // Hamming position of data bit idx: the idx-th non-power-of-two in 3..38.
    function automatic logic [5:0] data_pos(input int idx);
        int         cnt;
        logic [5:0] pos;
        cnt = 0;
        pos = 6'd0;
        for (int p = 3; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = 6'(p);
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [5:0] calc_check(input logic [31:0] d);
        logic [5:0] c;
        logic [5:0] pos;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            pos = data_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) c[k] = c[k] ^ d[i];
            end
        end
        return c;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [37:0] w;
        w = {calc_check(d), d};
        return {^w, w};
    endfunction

    assign w_syn   = calc_check(mem_rdata[31:0]) ^ mem_rdata[37:32];
    assign w_par   = ^mem_rdata;
    assign w_wdata = encode(w_cor_data);

    // Odd parity means one flipped bit; syndrome 0 or a check position leaves data alone.
    always_comb begin
        w_cor_data = mem_rdata[31:0];
        w_serr     = 1'b0;
        w_derr     = 1'b0;
        if (w_par) begin
            if (w_syn > 6'd38) begin
                w_derr = 1'b1;
            end else begin
                w_serr = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    if (data_pos(i) == w_syn) w_cor_data[i] = ~mem_rdata[i];
                end
            end
        end else if (w_syn != 6'd0) begin
            w_derr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = READ;
            READ:    w_state_nxt = CHECK;
            CHECK:   w_state_nxt = (w_serr && SCRUB_EN) ? WB : RESP;
            WB:      w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_last_err_addr <= '0;
            r_data          <= '0;
            r_serr          <= 1'b0;
            r_derr          <= 1'b0;
            r_wdata         <= '0;
            r_serr_cnt      <= '0;
            r_derr_cnt      <= '0;
        end else begin
            if (r_state == IDLE && req_valid) r_addr <= req_addr;
            if (r_state == CHECK) begin
                r_data  <= w_cor_data;
                r_serr  <= w_serr;
                r_derr  <= w_derr;
                r_wdata <= w_wdata;
                if (w_serr || w_derr) r_last_err_addr <= r_addr;
            end
            // Clear wins over an increment landing in the same cycle.
            if (clr_cnt) begin
                r_serr_cnt <= '0;
                r_derr_cnt <= '0;
            end else if (r_state == CHECK) begin
                if (w_serr && r_serr_cnt != 16'hFFFF) r_serr_cnt <= r_serr_cnt + 16'd1;
                if (w_derr && r_derr_cnt != 16'hFFFF) r_derr_cnt <= r_derr_cnt + 16'd1;
            end
        end
    end

    assign req_ready     = (r_state == IDLE) && rst_n;
    assign mem_rd_en     = (r_state == READ);
    assign mem_wr_en     = (r_state == WB);
    assign mem_addr      = (r_state == READ || r_state == WB) ? r_addr : '0;
    assign mem_wdata     = r_wdata;
    assign rsp_valid     = (r_state == RESP);
    assign rsp_data      = r_data;
    assign rsp_serr      = r_serr;
    assign rsp_derr      = r_derr;
    assign serr_cnt      = r_serr_cnt;
    assign derr_cnt      = r_derr_cnt;
    assign last_err_addr = r_last_err_addr;

endmodule
`default_nettype wire
